// File: rtl/shake_squeeze.sv
`default_nettype none
// ============================================================================
// Module   : shake_squeeze
// Purpose  : SHAKE squeeze engine. Streams the rate lanes of a permuted
//            Keccak state as 64-bit words over ready/valid and requests a
//            re-permutation whenever the rate is exhausted before the
//            requested word count is reached.
// Revision : 1.0 - initial release
// ============================================================================
module shake_squeeze #(
    parameter int STATE_WIDTH = 1600,
    parameter int W           = 64,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   out_len,
    input  logic [STATE_WIDTH-1:0] state_in,
    input  logic                   state_valid,
    output logic                   perm_req,
    output logic [STATE_WIDTH-1:0] perm_state,
    output logic [W-1:0]           dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int c_NUM_LANES = 25;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_EMIT = 3'd1;
    localparam logic [2:0] c_PERM = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]             r_state;
    logic [STATE_WIDTH-1:0] r_st;
    logic                   r_mode;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic [4:0]             r_idx;

    logic [W-1:0]           w_lane [c_NUM_LANES];
    logic                   w_last_lane;
    logic                   w_accept;

    // Lane k sits at the MSB end of the state: lane 0 is Aba, lane 1 is Abe.
    for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
        assign w_lane[k] = r_st[STATE_WIDTH-1-W*k -: W];
    end

    // Last rate lane: index 20 for SHAKE128 (rate 21), 16 for SHAKE256 (rate 17).
    assign w_last_lane = (r_idx == (r_mode ? 5'd16 : 5'd20));
    assign w_accept    = (r_state == c_EMIT) && dout_ready;

    // Main control FSM together with the held state and the word/lane counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_st    <= '0;
            r_mode  <= 1'b0;
            r_rem   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_st    <= state_in;
                        r_mode  <= mode;
                        r_rem   <= out_len;
                        r_idx   <= '0;
                        r_state <= (out_len == '0) ? c_DONE : c_EMIT;
                    end
                end
                c_EMIT: begin
                    if (w_accept) begin
                        r_rem <= r_rem - 1'b1;
                        // Wrap instead of stepping past the rate; the lane index
                        // is reloaded anyway when a fresh state arrives.
                        r_idx <= w_last_lane ? 5'd0 : r_idx + 5'd1;
                        if (r_rem == LEN_WIDTH'(1)) begin
                            r_state <= c_DONE;
                        end else if (w_last_lane) begin
                            r_state <= c_PERM;
                        end
                    end
                end
                c_PERM: begin
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (state_valid) begin
                        r_st    <= state_in;
                        r_idx   <= '0;
                        r_state <= c_EMIT;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; dout is forced to zero outside EMIT.
    assign dout_valid = (r_state == c_EMIT);
    assign dout       = dout_valid ? w_lane[r_idx] : '0;
    assign perm_req   = (r_state == c_PERM);
    assign perm_state = r_st;
    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shake_squeeze.sv
`default_nettype none
// ============================================================================
// Module   : tb_shake_squeeze
// Purpose  : Scoreboard bench for shake_squeeze. Expected words come from a
//            block/lane reference model over randomly generated states; a
//            monitor pops and compares on every accepted output word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake_squeeze;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          start;
    logic [15:0]   out_len;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          perm_req;
    logic [1599:0] perm_state;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          busy;
    logic          done;

    shake_squeeze #(.STATE_WIDTH(1600), .W(64), .LEN_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .start      (start),
        .out_len    (out_len),
        .state_in   (state_in),
        .state_valid(state_valid),
        .perm_req   (perm_req),
        .perm_state (perm_state),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic [1599:0] blk_states[$];
    logic [63:0]   exp_q[$];
    int            blk_ptr;
    int            perm_cnt;
    int            done_cnt = 0;
    int            done_exp_cyc = -1;
    int            word_no;
    bit            chk_en = 1'b1;
    bit            resp_en = 1'b1;
    bit            rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        s = '0;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [63:0] lane_of(input logic [1599:0] s, input int k);
        return s[1599-64*k -: 64];
    endfunction

    task automatic chk_zero(input string tag);
        check({tag, " dout_valid"}, 64'(dout_valid), 64'd0);
        check({tag, " perm_req"},   64'(perm_req),   64'd0);
        check({tag, " busy"},       64'(busy),       64'd0);
        check({tag, " done"},       64'(done),       64'd0);
        check({tag, " dout"},       dout,            64'd0);
        check({tag, " perm_state"}, 64'(|perm_state), 64'd0);
    endtask

    // Consumer backpressure: either always ready or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, done timing.
    initial begin
        bit          prev_stall = 1'b0;
        logic [63:0] prev_dout  = '0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (chk_en) begin
                if (prev_stall) begin
                    check("stall valid", 64'(dout_valid), 64'd1);
                    check("stall dout", dout, prev_dout);
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected word", dout, 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("word %0d", word_no), dout, e);
                        word_no++;
                        if (exp_q.size() == 0) done_exp_cyc = cyc + 1;
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_exp_cyc >= 0) check("done cycle", 64'(cyc), 64'(done_exp_cyc));
                    done_exp_cyc = -1;
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    // Permutation core stand-in: checks the held state, returns the next block.
    initial begin
        logic [1599:0] cur;
        int bad;
        forever begin
            @(negedge clk);
            if (perm_req && resp_en) begin
                perm_cnt++;
                cur = (blk_ptr - 1 < blk_states.size()) ? blk_states[blk_ptr-1] : '0;
                bad = -1;
                for (int k = 0; k < 25; k++)
                    if (bad < 0 && lane_of(perm_state, k) !== lane_of(cur, k)) bad = k;
                if (bad < 0) bad = 0;
                check($sformatf("perm_state lane %0d", bad), lane_of(perm_state, bad), lane_of(cur, bad));
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                state_in    = (blk_ptr < blk_states.size()) ? blk_states[blk_ptr] : rand_state();
                blk_ptr++;
                state_valid = 1'b1;
                @(posedge clk);
                #1;
                state_valid = 1'b0;
                state_in    = rand_state();
            end
        end
    end

    task automatic run(input logic m, input int len, input bit rr, input bit poke_start, input bit poke_sv);
        int rate;
        int nb;
        int dc0;
        int pe;
        int t;
        rate = m ? 17 : 21;
        t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        rdy_rand = rr;
        blk_states.delete();
        exp_q.delete();
        nb = (len == 0) ? 1 : (len + rate - 1) / rate;
        for (int b = 0; b < nb; b++) blk_states.push_back(rand_state());
        // Reference: word i is lane (i mod rate) of the (i div rate)-th state.
        for (int i = 0; i < len; i++) exp_q.push_back(lane_of(blk_states[i / rate], i % rate));
        blk_ptr  = 1;
        perm_cnt = 0;
        pe       = (len == 0) ? 0 : (len - 1) / rate;
        dc0      = done_cnt;
        word_no  = 0;
        @(posedge clk);
        #1;
        state_in = blk_states[0];
        mode     = m;
        out_len  = len[15:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        state_in = rand_state();
        mode     = ~m;
        out_len  = 16'($urandom);
        @(negedge clk);
        if (len == 0) begin
            check("zero-len done", 64'(done), 64'd1);
            check("zero-len valid", 64'(dout_valid), 64'd0);
        end else begin
            check("first valid latency", 64'(dout_valid), 64'd1);
        end
        if (poke_start) begin
            @(posedge clk);
            #1;
            start    = 1'b1;
            out_len  = 16'd3;
            state_in = rand_state();
            @(posedge clk);
            #1;
            start    = 1'b0;
        end
        if (poke_sv) begin
            @(posedge clk);
            #1;
            state_in    = rand_state();
            state_valid = 1'b1;
            @(posedge clk);
            #1;
            state_valid = 1'b0;
        end
        t = 0;
        while (done_cnt == dc0 && t < len * 30 + 200) begin @(negedge clk); t++; end
        @(negedge clk);
        check("done count", 64'(done_cnt - dc0), 64'd1);
        check("busy after done", 64'(busy), 64'd0);
        check("words left", 64'(exp_q.size()), 64'd0);
        check("perm count", 64'(perm_cnt), 64'(pe));
        exp_q.delete();
        rdy_rand = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_len = '0;
        state_in = '0; state_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run(1'b0, 5, 1'b0, 1'b0, 1'b0);
        run(1'b0, 22, 1'b0, 1'b0, 1'b0);
        run(1'b1, 40, 1'b0, 1'b0, 1'b0);
        run(1'b0, 30, 1'b1, 1'b0, 1'b0);
        run(1'b0, 0, 1'b0, 1'b0, 1'b0);
        run(1'b0, 30, 1'b1, 1'b1, 1'b0);
        run(1'b1, 10, 1'b0, 1'b0, 1'b1);
        repeat (6) run(1'($urandom_range(0, 1)), int'($urandom_range(1, 60)), 1'b1, 1'b0, 1'b0);

        // Reset while emitting.
        chk_en = 1'b0; resp_en = 1'b0;
        @(posedge clk); #1;
        state_in = rand_state(); mode = 1'b0; out_len = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("pre-reset emit valid", 64'(dout_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero("rst in EMIT");
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for the permutation result.
        @(posedge clk); #1;
        state_in = rand_state(); mode = 1'b0; out_len = 16'd22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!perm_req && t < 100);
        check("perm_req before wait reset", 64'(perm_req), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero("rst in WAIT");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1; resp_en = 1'b1;

        run(1'b0, 22, 1'b0, 1'b0, 1'b0);
        run(1'b1, 3, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
